// File: rtl/control_sequencer_if.sv
// control_sequencer_if: run/instruction/status inputs and datapath control strobes
// shared between the hardwired control sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int ALU_W = 5
) ();

    // Inputs to the sequencer
    logic              run;
    logic [31:0]       IR;
    logic              ConOut;
    logic              mem_ready;

    // Datapath control strobes
    logic              PCIn;
    logic              MARIn;
    logic              MDRIn;
    logic              IRIn;
    logic              YIn;
    logic              ZIn;
    logic              PCOut;
    logic              MDROut;
    logic              ZLoOut;
    logic              COut;
    logic              Gra;
    logic              Grb;
    logic              Grc;
    logic              RIn;
    logic              ROut;
    logic              BAOut;
    logic              Conin;
    logic              memread;
    logic              memwrite;
    logic [ALU_W-1:0]  ALUCode;

    // Status
    logic              halted;
    logic              illegal;

    modport master (
        input  run, IR, ConOut, mem_ready,
        output PCIn, MARIn, MDRIn, IRIn, YIn, ZIn, PCOut, MDROut, ZLoOut, COut,
               Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite,
               ALUCode, halted, illegal
    );

    modport slave (
        output run, IR, ConOut, mem_ready,
        input  PCIn, MARIn, MDRIn, IRIn, YIn, ZIn, PCOut, MDROut, ZLoOut, COut,
               Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite,
               ALUCode, halted, illegal
    );

endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit. A state machine walks
// IDLE -> T0..T7 -> T0/IDLE (or HALT), and the datapath strobes are decoded from
// the current state and the opcode in IR[31:27]. Memory states stall on mem_ready.
// Build option: define CSEQ_BRANCH_EN to execute opcode 10011 as a conditional
// branch; without it that opcode is reported as illegal like any unknown opcode.
module control_sequencer #(
    parameter int               ALU_W    = 5,
    parameter logic [ALU_W-1:0] INC_CODE = ALU_W'(5'b11111)
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    // ------------------------------------------------------------------
    // Opcodes (IR[31:27])
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Address and branch-target arithmetic all use the adder
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(5'b00011);

`ifdef CSEQ_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    function automatic logic is_reg_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_known(input logic [4:0] op);
        return (op == OP_LD)   || (op == OP_LDI) || (op == OP_ST) ||
               is_reg_alu(op)  || (op == OP_ADDI) || (op == OP_HALT) ||
               (BRANCH_EN && (op == OP_BR));
    endfunction

    logic [4:0] opcode;
    logic       op_ld;
    logic       op_ldi;
    logic       op_st;
    logic       op_rr;
    logic       op_addi;
    logic       op_br;
    logic       op_halt;
    logic       op_known;

    assign opcode   = bus.IR[31:27];
    assign op_ld    = (opcode == OP_LD);
    assign op_ldi   = (opcode == OP_LDI);
    assign op_st    = (opcode == OP_ST);
    assign op_rr    = is_reg_alu(opcode);
    assign op_addi  = (opcode == OP_ADDI);
    assign op_br    = BRANCH_EN && (opcode == OP_BR);
    assign op_halt  = (opcode == OP_HALT);
    assign op_known = is_known(opcode);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       illegal_q;
    logic       illegal_d;
    logic [3:0] end_state;

    // Where an instruction goes after its final step: keep fetching only while run is high
    assign end_state = bus.run ? S_T0 : S_IDLE;

    // Bad opcode flag: raised while T3 decodes it, then held until reset
    assign illegal_d = illegal_q | ((state_q == S_T3) && !op_known);

    // State and sticky flag, cleared asynchronously by clear
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing, including memory stalls and per-opcode instruction length
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_T0;
            end
            S_T0: state_d = S_T1;
            S_T1: begin
                if (bus.mem_ready) state_d = S_T2;
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (op_halt || !op_known) state_d = S_HALT;
                else                      state_d = S_T4;
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (op_ld || op_st || op_br) state_d = S_T6;
                else                         state_d = end_state;
            end
            S_T6: begin
                if (op_ld) begin
                    if (bus.mem_ready) state_d = S_T7;
                end else if (op_st) begin
                    state_d = S_T7;
                end else begin
                    // Branch finishes here; anything else only lands here if IR changed mid-flight
                    state_d = end_state;
                end
            end
            S_T7: begin
                if (op_st) begin
                    if (bus.mem_ready) state_d = end_state;
                end else begin
                    state_d = end_state;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------
    logic             pc_in;
    logic             mar_in;
    logic             mdr_in;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             pc_out;
    logic             mdr_out;
    logic             zlo_out;
    logic             c_out;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             r_in;
    logic             r_out;
    logic             ba_out;
    logic             con_in;
    logic             mem_read;
    logic             mem_write;
    logic [ALU_W-1:0] alu_code;

    // Moore decode of state and opcode; PCIn additionally follows mem_ready in T1
    // (advance PC only when the fetch completes) and ConOut in the branch T6
    always_comb begin
        pc_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        pc_out    = 1'b0;
        mdr_out   = 1'b0;
        zlo_out   = 1'b0;
        c_out     = 1'b0;
        gra       = 1'b0;
        grb       = 1'b0;
        grc       = 1'b0;
        r_in      = 1'b0;
        r_out     = 1'b0;
        ba_out    = 1'b0;
        con_in    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_code  = '0;
        case (state_q)
            S_T0: begin
                pc_out   = 1'b1;
                mar_in   = 1'b1;
                z_in     = 1'b1;
                alu_code = INC_CODE;
            end
            S_T1: begin
                zlo_out  = 1'b1;
                pc_in    = bus.mem_ready;
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (op_ld || op_ldi || op_st) begin
                    grb    = 1'b1;
                    ba_out = 1'b1;
                    y_in   = 1'b1;
                end else if (op_rr || op_addi) begin
                    grb   = 1'b1;
                    r_out = 1'b1;
                    y_in  = 1'b1;
                end else if (op_br) begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    con_in = 1'b1;
                end
            end
            S_T4: begin
                if (op_ld || op_ldi || op_st || op_addi) begin
                    c_out    = 1'b1;
                    z_in     = 1'b1;
                    alu_code = ALU_ADD;
                end else if (op_rr) begin
                    grc      = 1'b1;
                    r_out    = 1'b1;
                    z_in     = 1'b1;
                    alu_code = ALU_W'(opcode);
                end else if (op_br) begin
                    pc_out = 1'b1;
                    y_in   = 1'b1;
                end
            end
            S_T5: begin
                if (op_ld || op_st) begin
                    zlo_out = 1'b1;
                    mar_in  = 1'b1;
                end else if (op_ldi || op_rr || op_addi) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (op_br) begin
                    c_out    = 1'b1;
                    z_in     = 1'b1;
                    alu_code = ALU_ADD;
                end
            end
            S_T6: begin
                if (op_ld) begin
                    mem_read = 1'b1;
                    mdr_in   = 1'b1;
                end else if (op_st) begin
                    gra    = 1'b1;
                    r_out  = 1'b1;
                    mdr_in = 1'b1;
                end else if (op_br) begin
                    zlo_out = bus.ConOut;
                    pc_in   = bus.ConOut;
                end
            end
            S_T7: begin
                if (op_ld) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (op_st) begin
                    mem_write = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.PCIn     = pc_in;
    assign bus.MARIn    = mar_in;
    assign bus.MDRIn    = mdr_in;
    assign bus.IRIn     = ir_in;
    assign bus.YIn      = y_in;
    assign bus.ZIn      = z_in;
    assign bus.PCOut    = pc_out;
    assign bus.MDROut   = mdr_out;
    assign bus.ZLoOut   = zlo_out;
    assign bus.COut     = c_out;
    assign bus.Gra      = gra;
    assign bus.Grb      = grb;
    assign bus.Grc      = grc;
    assign bus.RIn      = r_in;
    assign bus.ROut     = r_out;
    assign bus.BAOut    = ba_out;
    assign bus.Conin    = con_in;
    assign bus.memread  = mem_read;
    assign bus.memwrite = mem_write;
    assign bus.ALUCode  = alu_code;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.illegal  = illegal_d;

endmodule
